// File: rtl/add_pipe_pkg.sv
// Shared constants and data types for the pipelined adder and anything that
// produces or consumes its operands and sums.
package add_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SPLIT_DEF = 16;
  localparam int CNT_W_DEF = 16;

  typedef logic [WIDTH_DEF-1:0] operand_t;
  typedef logic [WIDTH_DEF:0]   sum_t;

endpackage

// File: rtl/add_pipe_stage.sv
// Generic valid/ready register slice: one payload register plus its valid bit.
// The slice accepts whenever it is empty or being drained in the same cycle.
module add_pipe_stage
  import add_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_reg;
  logic [W-1:0] data_reg;

  assign in_ready  = !valid_reg || out_ready;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;

  // Payload loads only on an actual transfer, so idle inputs never disturb it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (in_ready) begin
      valid_reg <= in_valid;
      if (in_valid) begin
        data_reg <= in_data;
      end
    end
  end

endmodule

// File: rtl/add_pipe.sv
// Two-stage pipelined unsigned adder with valid/ready on both sides; the add
// is split at bit SPLIT so each stage carries only a partial carry chain.
module add_pipe
  import add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SPLIT = SPLIT_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic [CNT_W-1:0] txn_count
);

  localparam int HI_W = WIDTH - SPLIT;
  localparam int S1_W = 2 * HI_W + SPLIT + 1;
  localparam int S2_W = WIDTH + 1;

  // Stage 1 payload: {a_hi, b_hi, lo} where lo carries c1 in its MSB.
  logic [SPLIT:0]  lo_sum;
  logic [S1_W-1:0] s1_in;
  logic [S1_W-1:0] s1_data;
  logic            s1_valid;
  logic            s2_adv;

  assign lo_sum = {1'b0, a[SPLIT-1:0]} + {1'b0, b[SPLIT-1:0]};
  assign s1_in  = {a[WIDTH-1:SPLIT], b[WIDTH-1:SPLIT], lo_sum};

  add_pipe_stage #(
    .W (S1_W)
  ) u_s1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_adv),
    .out_data  (s1_data)
  );

  logic [HI_W-1:0] s1_a_hi;
  logic [HI_W-1:0] s1_b_hi;
  logic [SPLIT:0]  s1_lo;
  logic [HI_W:0]   hi_sum;
  logic [S2_W-1:0] s2_in;

  assign s1_a_hi = s1_data[S1_W-1 -: HI_W];
  assign s1_b_hi = s1_data[SPLIT+1 +: HI_W];
  assign s1_lo   = s1_data[SPLIT:0];
  assign hi_sum  = {1'b0, s1_a_hi} + {1'b0, s1_b_hi} + {{HI_W{1'b0}}, s1_lo[SPLIT]};
  assign s2_in   = {hi_sum, s1_lo[SPLIT-1:0]};

  add_pipe_stage #(
    .W (S2_W)
  ) u_s2 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s1_valid),
    .in_ready  (s2_adv),
    .in_data   (s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (sum)
  );

  logic [CNT_W-1:0] txn_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txn_count_reg <= '0;
    end else if (out_valid && out_ready) begin
      txn_count_reg <= txn_count_reg + CNT_W'(1);
    end
  end

  assign txn_count = txn_count_reg;

endmodule

// File: tb/tb_add_pipe.sv
// Directed bench for add_pipe: table of single operations, then streaming,
// back-pressure, reset mid-flight and counter wrap sequences.
module tb_add_pipe;
  import add_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  operand_t      a;
  operand_t      b;
  logic          out_valid;
  logic          out_ready;
  sum_t          sum;
  logic [CW-1:0] txn_count;

  always #5 clk = ~clk;

  add_pipe #(
    .WIDTH (WIDTH_DEF),
    .SPLIT (SPLIT_DEF),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .txn_count (txn_count)
  );

  typedef struct {
    operand_t a;
    operand_t b;
    sum_t     s;
  } vec_t;

  vec_t vecs[7];
  int   checks   = 0;
  int   failures = 0;
  sum_t exp_q[$];
  int   exp_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // One clock: drive inputs, sample handshakes before the edge, then score
  // whatever transferred on that edge against the bench's own sum model.
  task automatic cycle(input logic iv, input operand_t ia, input operand_t ib,
                       input logic ordy, output logic acc);
    logic xfer;
    sum_t s_pre;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    out_ready = ordy;
    #1;
    acc   = in_valid && in_ready;
    xfer  = out_valid && out_ready;
    s_pre = sum;
    @(posedge clk);
    #1;
    if (xfer) begin
      exp_cnt++;
      chk("xfer_has_item", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk("sum_order", 64'(s_pre), 64'(exp_q.pop_front()));
      chk("txn_count", 64'(txn_count), 64'(exp_cnt % 16));
    end
    if (acc) exp_q.push_back(sum_t'({1'b0, ia} + {1'b0, ib}));
  endtask

  task automatic drain(input string tag);
    logic acc;
    for (int k = 0; k < 12; k++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      cycle(1'b0, '0, '0, 1'b1, acc);
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Single operation from an empty pipe with the 2-cycle latency checked.
  task automatic run_vec(input operand_t va, input operand_t vb, input sum_t vs);
    logic acc;
    cycle(1'b1, va, vb, 1'b1, acc);
    chk("vec_accept", 64'(acc), 64'd1);
    chk("vec_lat1_out_valid", 64'(out_valid), 64'd0);
    cycle(1'b0, '0, '0, 1'b1, acc);
    chk("vec_lat2_out_valid", 64'(out_valid), 64'd1);
    chk("vec_sum", 64'(sum), 64'(vs));
    cycle(1'b0, '0, '0, 1'b1, acc);
    chk("vec_drained", 64'(out_valid), 64'd0);
  endtask

  function automatic operand_t bp_a(input int k);
    return 32'hF000_0000 + operand_t'(k);
  endfunction

  function automatic operand_t bp_b(input int k);
    return 32'h1100_0000 + operand_t'(k * 3);
  endfunction

  initial begin
    logic acc;
    int   src;
    int   start_cnt;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000};
    vecs[1] = '{32'h0000_FFFF, 32'h0000_0001, 33'h0_0001_0000};
    vecs[2] = '{32'h1234_5678, 32'h9ABC_DEF0, 33'h0_ACF1_3568};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 33'h0_0000_0000};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE};
    vecs[5] = '{32'h8000_0000, 32'h8000_0000, 33'h1_0000_0000};
    vecs[6] = '{32'h0000_FFFF, 32'h0000_FFFF, 33'h0_0001_FFFE};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_txn_count", 64'(txn_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i].a, vecs[i].b, vecs[i].s);
      $display("vec %0d: a=0x%08h b=0x%08h sum=0x%09h txn_count=%0d", i, vecs[i].a, vecs[i].b, vecs[i].s, txn_count);
    end
    chk("single_ops_count", 64'(txn_count), 64'd7);

    // Back-to-back: 8 accepts, outputs on 8 consecutive cycles.
    for (int i = 0; i < 10; i++) begin
      cycle(i < 8, operand_t'(i), operand_t'(i), 1'b1, acc);
      if (i < 8) chk("b2b_in_ready", 64'(acc), 64'd1);
      if (i >= 1 && i <= 8) begin
        chk("b2b_out_valid", 64'(out_valid), 64'd1);
        chk("b2b_sum", 64'(sum), 64'(2 * (i - 1)));
      end
      $display("b2b cycle %0d: out_valid=%0b sum=0x%09h", i, out_valid, sum);
    end
    chk("b2b_empty", 64'(exp_q.size()), 64'd0);
    chk("b2b_out_valid_end", 64'(out_valid), 64'd0);

    // Back-pressure: out_ready low for 5 cycles while a source streams 6 items.
    src       = 0;
    start_cnt = exp_cnt;
    for (int cyc = 0; cyc < 25; cyc++) begin
      if (src >= 6 && exp_q.size() == 0 && !out_valid) break;
      cycle(src < 6, bp_a(src), bp_b(src), cyc >= 5, acc);
      if (cyc < 5) chk("bp_in_ready", 64'(acc), 64'(cyc < 2));
      if (cyc >= 1 && cyc <= 4) begin
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_sum", 64'(sum), 64'h1_0100_0000);
      end
      if (acc) src++;
      $display("bp cycle %0d: accepted=%0b out_valid=%0b sum=0x%09h", cyc, acc, out_valid, sum);
    end
    chk("bp_all_sent", 64'(src), 64'd6);
    chk("bp_total_xfers", 64'(exp_cnt - start_cnt), 64'd6);
    chk("bp_empty", 64'(exp_q.size()), 64'd0);

    // Reset with two results in flight.
    cycle(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0, acc);
    cycle(1'b1, 32'h0000_0030, 32'h0000_0040, 1'b0, acc);
    chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_txn_count", 64'(txn_count), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    $display("mid-op reset: out_valid=%0b txn_count=%0d", out_valid, txn_count);
    exp_q.delete();
    exp_cnt   = 0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_held_out_valid", 64'(out_valid), 64'd0);
    reset = 1'b0;
    run_vec(32'd3, 32'd4, 33'd7);
    chk("post_rst_count", 64'(txn_count), 64'd1);

    // Counter wrap: 16 more transfers make 17 since reset.
    src = 0;
    for (int cyc = 0; cyc < 20 && src < 16; cyc++) begin
      cycle(1'b1, operand_t'(100 + src), operand_t'(src), 1'b1, acc);
      if (acc) src++;
    end
    drain("wrap_drain");
    chk("wrap_txn_count", 64'(txn_count), 64'd1);
    $display("wrap: transfers=%0d txn_count=%0d", exp_cnt, txn_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
